// File: rtl/mem_defs.sv
// Shared definitions for the data memory controller: access sizes and FSM states.
package mem_defs;

   // Access-size encoding driven unchanged by the load/store control path.
   typedef enum logic [1:0] {
      SIZE_NONE = 2'b00,
      SIZE_BYTE = 2'b01,
      SIZE_HALF = 2'b10,
      SIZE_WORD = 2'b11
   } size_e;

   // Controller states: accepting, counting wait states, presenting the response.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering between the 32-bit array word and right-justified CPU data.
module mem_lane_align
   import mem_defs::*;
(
   input  size_e       size_i,
   input  logic [1:0]  lane_i,
   input  logic        signed_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] load_word_i,
   output logic [3:0]  byte_en_o,
   output logic [31:0] store_word_o,
   output logic [31:0] load_data_o
);

   logic [31:0] shifted;

   // Addressed lanes moved down to bit 0; halfword lanes are 0 or 2 so the same shift serves.
   assign shifted = load_word_i >> {lane_i, 3'b000};

   // Store path: byte enables plus store data replicated into every candidate lane.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      byte_en_o    = 4'b0000;
      store_word_o = 32'h0;
      unique case (size_i)
         SIZE_BYTE: begin
            byte_en_o    = 4'b0001 << lane_i;
            store_word_o = {4{store_data_i[7:0]}};
         end
         SIZE_HALF: begin
            byte_en_o    = lane_i[1] ? 4'b1100 : 4'b0011;
            store_word_o = {2{store_data_i[15:0]}};
         end
         SIZE_WORD: begin
            byte_en_o    = 4'b1111;
            store_word_o = store_data_i;
         end
         default: ;
      endcase
   end

   // Load path: right-justified lane with sign or zero extension (words pass through).
   always_comb begin
      load_data_o = 32'h0;
      unique case (size_i)
         SIZE_BYTE: load_data_o = {{24{signed_i & shifted[7]}},  shifted[7:0]};
         SIZE_HALF: load_data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
         SIZE_WORD: load_data_o = shifted;
         default: ;
      endcase
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked byte/half/word data memory with programmable wait states and fault reporting.
module data_memory_ctrl
   import mem_defs::*;
#(
   parameter int ADDR_W  = 10,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 1
) (
   input  logic              clk_i,
   input  logic              n_rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic              signed_i,
   input  logic [ADDR_W-1:0] address_i,
   input  logic [31:0]       write_data_i,
   output logic              ready_o,
   output logic              valid_o,
   output logic              err_o,
   output logic [31:0]       read_data_o
);

   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                AQ_W    = IDX_W + 2;
   localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH);
   localparam logic [CNT_W-1:0]  LAT_L   = CNT_W'(LATENCY);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              we_q, signed_q;
   size_e             size_q;
   logic [AQ_W-1:0]   addr_q;
   logic [31:0]       wdata_q;

   logic [31:0]       mem_q [DEPTH];

   size_e             req_size, acc_size;
   logic              in_idle, fault, access_go;
   logic              acc_we, acc_signed;
   logic [AQ_W-1:0]   acc_addr;
   logic [31:0]       acc_wdata;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        byte_en;
   logic [31:0]       store_word, load_data, load_word;

   assign in_idle  = (state_q == ST_IDLE);
   assign req_size = size_e'(size_i);

   // Faults are judged on the request as presented at the accept edge.
   assign fault = (req_size == SIZE_NONE)
                | ((req_size == SIZE_HALF) & address_i[0])
                | ((req_size == SIZE_WORD) & (address_i[1:0] != 2'b00))
                | ({1'b0, address_i[ADDR_W-1:2]} >= DEPTH_L);

   // Zero-latency accesses use the live request; delayed ones use the captured copy.
   assign acc_we     = in_idle ? we_i         : we_q;
   assign acc_size   = in_idle ? req_size     : size_q;
   assign acc_signed = in_idle ? signed_i     : signed_q;
   assign acc_addr   = in_idle ? address_i[AQ_W-1:0] : addr_q;
   assign acc_wdata  = in_idle ? write_data_i : wdata_q;
   assign access_go  = in_idle ? (req_i & ~fault & (LATENCY == 0))
                               : ((state_q == ST_WAIT) & (cnt_q == CNT_W'(1)));
   assign idx        = acc_addr[AQ_W-1:2];
   assign load_word  = mem_q[idx];

   mem_lane_align u_align (
      .size_i       (acc_size),
      .lane_i       (acc_addr[1:0]),
      .signed_i     (acc_signed),
      .store_data_i (acc_wdata),
      .load_word_i  (load_word),
      .byte_en_o    (byte_en),
      .store_word_o (store_word),
      .load_data_o  (load_data)
   );

   // Array write: only the enabled lanes change on the access edge.
   // NOTE: the array has no reset; its contents are undefined until written, which keeps it mappable to RAM.
   always_ff @(posedge clk_i) begin
      if (access_go && acc_we) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem_q[idx][8*b +: 8] <= store_word[8*b +: 8];
         end
      end
   end

   // Capture the request at acceptance so it survives the wait states.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         we_q     <= 1'b0;
         size_q   <= SIZE_NONE;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
      end else if (req_i && in_idle) begin
         we_q     <= we_i;
         size_q   <= req_size;
         signed_q <= signed_i;
         addr_q   <= address_i[AQ_W-1:0];
         wdata_q  <= write_data_i;
      end
   end

   // State, wait counter and registered response.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!n_rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next state; response data defaults to zero so it is non-zero only during RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = 32'h0;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               if (fault) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
               end else if (LATENCY == 0) begin
                  state_d = ST_RESP;
                  rdata_d = acc_we ? 32'h0 : load_data;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_L;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
               rdata_d = acc_we ? 32'h0 : load_data;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign ready_o     = in_idle;
   assign valid_o     = (state_q == ST_RESP);
   assign err_o       = err_q;
   assign read_data_o = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (LATENCY=2/DEPTH=256, LATENCY=3/DEPTH=192)
// compared every cycle against a transaction-level model, plus literal expectations.
module tb_data_memory_ctrl;

   localparam int LAT [2] = '{2, 3};
   localparam int DEP [2] = '{256, 192};

   logic        clk = 1'b0;
   logic        n_rst [2];
   logic        req [2], we [2], sgn [2];
   logic [1:0]  size [2];
   logic [9:0]  addr [2];
   logic [31:0] wdata [2];
   logic        ready [2], valid [2], err [2];
   logic [31:0] rdata [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_memory_ctrl #(.ADDR_W(10), .DEPTH(256), .LATENCY(2)) dut0 (
      .clk_i(clk), .n_rst_i(n_rst[0]), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
      .signed_i(sgn[0]), .address_i(addr[0]), .write_data_i(wdata[0]),
      .ready_o(ready[0]), .valid_o(valid[0]), .err_o(err[0]), .read_data_o(rdata[0]));

   data_memory_ctrl #(.ADDR_W(10), .DEPTH(192), .LATENCY(3)) dut1 (
      .clk_i(clk), .n_rst_i(n_rst[1]), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
      .signed_i(sgn[1]), .address_i(addr[1]), .write_data_i(wdata[1]),
      .ready_o(ready[1]), .valid_o(valid[1]), .err_o(err[1]), .read_data_o(rdata[1]));

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] mm [2][256];
   bit          m_act [2], m_we [2], m_sgn [2], m_fault [2], m_err [2];
   int          m_left [2];
   logic [1:0]  m_size [2];
   logic [9:0]  m_addr [2];
   logic [31:0] m_wd [2], m_rd [2];

   function automatic bit is_fault(input logic [1:0] sz, input logic [9:0] a, input int depth);
      return (sz == 2'b00) || (sz == 2'b10 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00)
             || (int'(a >> 2) >= depth);
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                            input bit sg, input int lane);
      logic [31:0] s;
      s = w >> (8 * lane);
      if (sz == 2'b01) begin
         s = s & 32'hFF;
         if (sg && s[7]) s = s | 32'hFFFF_FF00;
      end else if (sz == 2'b10) begin
         s = s & 32'hFFFF;
         if (sg && s[15]) s = s | 32'hFFFF_0000;
      end else begin
         s = w;
      end
      return s;
   endfunction

   task automatic perform(input int k);
      int idx, lane, n;
      logic [31:0] w;
      if (m_fault[k]) begin
         m_rd[k]  = 32'h0;
         m_err[k] = 1'b1;
         return;
      end
      idx  = int'(m_addr[k] >> 2);
      lane = int'(m_addr[k][1:0]);
      n    = (m_size[k] == 2'b01) ? 1 : (m_size[k] == 2'b10) ? 2 : 4;
      m_err[k] = 1'b0;
      if (m_we[k]) begin
         w = mm[k][idx];
         for (int i = 0; i < n; i++) w[8*(lane+i) +: 8] = m_wd[k][8*i +: 8];
         mm[k][idx] = w;
         m_rd[k] = 32'h0;
      end else begin
         m_rd[k] = load_val(mm[k][idx], m_size[k], m_sgn[k], lane);
      end
   endtask

   // Model advances one clock at a time; the access happens when the wait count runs out.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!n_rst[k]) begin
            m_act[k] = 1'b0; m_left[k] = 0; m_rd[k] = 32'h0; m_err[k] = 1'b0;
         end else if (m_act[k]) begin
            if (m_left[k] == 0) m_act[k] = 1'b0;
            else begin
               m_left[k]--;
               if (m_left[k] == 0) perform(k);
            end
         end else if (req[k]) begin
            m_act[k]   = 1'b1;
            m_we[k]    = we[k];
            m_size[k]  = size[k];
            m_sgn[k]   = sgn[k];
            m_addr[k]  = addr[k];
            m_wd[k]    = wdata[k];
            m_fault[k] = is_fault(size[k], addr[k], DEP[k]);
            m_left[k]  = m_fault[k] ? 0 : LAT[k];
            if (m_left[k] == 0) perform(k);
         end
      end
   end

   // Every cycle, away from the rising edge, all outputs of both instances against the model.
   always @(negedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         logic er, ev, ee;
         logic [31:0] ed;
         if (!n_rst[k]) begin
            er = 1'b1; ev = 1'b0; ee = 1'b0; ed = 32'h0;
         end else begin
            er = !m_act[k];
            ev = m_act[k] && (m_left[k] == 0);
            ee = ev ? m_err[k] : 1'b0;
            ed = ev ? m_rd[k] : 32'h0;
         end
         check("ready_o", k, 32'(ready[k]), 32'(er));
         check("valid_o", k, 32'(valid[k]), 32'(ev));
         check("err_o", k, 32'(err[k]), 32'(ee));
         check("read_data_o", k, rdata[k], ed);
      end
   end

   // ---------------- driver ----------------
   // mode 0: drop req after accept; 1: hold req high with another address; 2: random noise.
   task automatic access(input int k, input bit w, input logic [1:0] sz, input bit sg,
                         input logic [9:0] a, input logic [31:0] d, input int mode,
                         output logic [31:0] rd, output logic er, output int lat);
      int guard = 0;
      rd = 32'h0; er = 1'b0; lat = 0;
      @(negedge clk);
      while (!ready[k] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!ready[k]) begin
         check("idle_timeout", k, 32'(ready[k]), 32'd1);
         return;
      end
      we[k] = w; size[k] = sz; sgn[k] = sg; addr[k] = a; wdata[k] = d; req[k] = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (valid[k]) begin
            lat = c; rd = rdata[k]; er = err[k];
            break;
         end
         if (mode == 1) begin
            addr[k] = a ^ 10'h020; we[k] = 1'b1; wdata[k] = 32'h0;
            check("ready_busy", k, 32'(ready[k]), 32'd0);
         end else if (mode == 2) begin
            req[k] = 1'($urandom); we[k] = 1'($urandom);
            addr[k] = 10'($urandom); wdata[k] = $urandom;
         end else begin
            req[k] = 1'b0;
         end
      end
      req[k] = 1'b0;
      if (lat == 0) check("resp_timeout", k, 32'(valid[k]), 32'd1);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;

   initial begin
      for (int k = 0; k < 2; k++) begin
         n_rst[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; sgn[k] = 1'b0;
         size[k] = 2'b00; addr[k] = '0; wdata[k] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", 0, 32'(ready[0]), 32'd1);
      check("reset_valid", 1, 32'(valid[1]), 32'd0);
      #2;
      n_rst[0] = 1'b1; n_rst[1] = 1'b1;

      // Give the model and both arrays known contents in words 0..15.
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16; i++) access(k, 1, 2'b11, 0, 10'(i*4), $urandom, 0, rd, er, lat);

      // Word store/load, LATENCY=2.
      access(0, 1, 2'b11, 0, 10'h0C, 32'h12345678, 0, rd, er, lat);
      check("st_word_lat", 0, lat, 3); check("st_word_err", 0, 32'(er), 0); check("st_word_rd", 0, rd, 0);
      access(0, 0, 2'b11, 0, 10'h0C, 32'h0, 0, rd, er, lat);
      check("ld_word_lat", 0, lat, 3); check("ld_word_rd", 0, rd, 32'h12345678);

      // Halfword and byte lanes.
      access(0, 1, 2'b11, 0, 10'h04, 32'h12345678, 0, rd, er, lat);
      access(0, 1, 2'b10, 0, 10'h06, 32'h1234BEEF, 0, rd, er, lat);
      access(0, 0, 2'b11, 0, 10'h04, 32'h0, 0, rd, er, lat);
      check("half_merge", 0, rd, 32'hBEEF5678);
      access(0, 0, 2'b10, 1, 10'h06, 32'h0, 0, rd, er, lat);
      check("ld_half_s", 0, rd, 32'hFFFFBEEF);
      access(0, 0, 2'b10, 0, 10'h06, 32'h0, 0, rd, er, lat);
      check("ld_half_u", 0, rd, 32'h0000BEEF);
      access(0, 1, 2'b01, 0, 10'h07, 32'hABCDEFF0, 0, rd, er, lat);
      access(0, 0, 2'b01, 1, 10'h07, 32'h0, 0, rd, er, lat);
      check("ld_byte_s", 0, rd, 32'hFFFFFFF0);
      access(0, 0, 2'b11, 1, 10'h04, 32'h0, 0, rd, er, lat);
      check("byte_merge", 0, rd, 32'hF0EF5678);

      // Request held during WAIT is ignored: one pulse, then idle.
      access(0, 0, 2'b11, 0, 10'h0C, 32'h0, 1, rd, er, lat);
      check("hold_lat", 0, lat, 3); check("hold_rd", 0, rd, 32'h12345678);
      @(negedge clk);
      check("hold_single", 0, 32'(valid[0]), 0); check("hold_ready", 0, 32'(ready[0]), 1);
      access(0, 0, 2'b11, 0, 10'h2C, 32'h0, 0, rd, er, lat);
      check("hold_no_store", 0, rd, mm[0][11]);

      // Reset during WAIT of a store drops it.
      access(0, 1, 2'b11, 0, 10'h10, 32'h11111111, 0, rd, er, lat);
      @(negedge clk);
      we[0] = 1'b1; size[0] = 2'b11; sgn[0] = 1'b0; addr[0] = 10'h10; wdata[0] = 32'hDEADBEEF; req[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req[0] = 1'b0;
      check("wait_busy", 0, 32'(ready[0]), 0);
      #2 n_rst[0] = 1'b0;
      #1;
      check("rst_ready", 0, 32'(ready[0]), 1); check("rst_valid", 0, 32'(valid[0]), 0);
      check("rst_err", 0, 32'(err[0]), 0); check("rst_rd", 0, rdata[0], 0);
      repeat (4) begin
         @(negedge clk);
         check("rst_no_valid", 0, 32'(valid[0]), 0);
      end
      #2 n_rst[0] = 1'b1;
      access(0, 0, 2'b11, 0, 10'h10, 32'h0, 0, rd, er, lat);
      check("rst_kept", 0, rd, 32'h11111111);

      // Faults, LATENCY=3.
      access(1, 0, 2'b11, 0, 10'h08, 32'h0, 0, rd, er, lat);
      check("ok_lat_l3", 1, lat, 4);
      access(1, 1, 2'b11, 0, 10'h04, 32'hAAAAAAAA, 0, rd, er, lat);
      access(1, 1, 2'b11, 0, 10'h05, 32'h55555555, 0, rd, er, lat);
      check("f_word_lat", 1, lat, 1); check("f_word_err", 1, 32'(er), 1); check("f_word_rd", 1, rd, 0);
      access(1, 0, 2'b11, 0, 10'h04, 32'h0, 0, rd, er, lat);
      check("f_word_keep", 1, rd, 32'hAAAAAAAA);
      access(1, 1, 2'b11, 0, 10'h00, 32'hCCCCCCCC, 0, rd, er, lat);
      access(1, 1, 2'b10, 0, 10'h03, 32'h00007777, 0, rd, er, lat);
      check("f_half_lat", 1, lat, 1); check("f_half_err", 1, 32'(er), 1);
      access(1, 0, 2'b11, 0, 10'h00, 32'h0, 0, rd, er, lat);
      check("f_half_keep", 1, rd, 32'hCCCCCCCC);
      access(1, 1, 2'b11, 0, 10'h08, 32'h99999999, 0, rd, er, lat);
      access(1, 1, 2'b00, 0, 10'h08, 32'h12121212, 0, rd, er, lat);
      check("f_none_lat", 1, lat, 1); check("f_none_err", 1, 32'(er), 1);
      access(1, 0, 2'b11, 0, 10'h08, 32'h0, 0, rd, er, lat);
      check("f_none_keep", 1, rd, 32'h99999999);
      access(1, 0, 2'b11, 0, 10'h300, 32'h0, 0, rd, er, lat);
      check("f_range_lat", 1, lat, 1); check("f_range_err", 1, 32'(er), 1); check("f_range_rd", 1, rd, 0);

      // Random traffic; the per-cycle compare process does the checking.
      for (int n = 0; n < 300; n++) begin
         int k;
         logic [9:0] a;
         k = n % 2;
         a = 10'($urandom_range(0, 63));
         if (k == 1 && $urandom_range(0, 7) == 0) a = 10'(768 + $urandom_range(0, 255));
         access(k, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                ($urandom_range(0, 3) == 0) ? 2 : 0, rd, er, lat);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
